// File: rtl/ysyx_24080014_gpr_wb_arb.sv
// GPR write-back arbiter: round-robin EXU/LSU share of the single register-file
// write port, one-cycle write register, and a pending-write scoreboard for issue.
module ysyx_24080014_gpr_wb_arb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    exu_valid,
    output logic                    exu_ready,
    input  logic [$clog2(NREG)-1:0] exu_rd,
    input  logic [XLEN-1:0]         exu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [$clog2(NREG)-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rs1,
    input  logic [$clog2(NREG)-1:0] iss_rs2,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                    iss_stall,
    output logic                    RegWr,
    output logic [$clog2(NREG)-1:0] rd,
    output logic [XLEN-1:0]         rd_data,
    output logic                    sb_busy
);
    localparam int IW = $clog2(NREG);

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

    gnt_e            last_grant_q, last_grant_d;
    logic            regwr_q, regwr_d;
    logic [IW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            exu_gnt, lsu_gnt, xfer, iss_fire;
    logic [IW-1:0]   g_rd;
    logic [XLEN-1:0] g_data;

    // Grants are held low during reset so nothing transfers in that cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        exu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (rst_n) begin
            if (exu_valid && lsu_valid) begin
                exu_gnt = (last_grant_q == GNT_LSU);
                lsu_gnt = (last_grant_q == GNT_EXU);
            end else begin
                exu_gnt = exu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign exu_ready = exu_gnt;
    assign lsu_ready = lsu_gnt;
    assign xfer      = exu_gnt | lsu_gnt;
    assign g_rd      = exu_gnt ? exu_rd   : lsu_rd;
    assign g_data    = exu_gnt ? exu_data : lsu_data;

    // No forwarding: a register stays hazardous until the edge that writes it.
    assign iss_stall = rst_n & iss_valid &
                       (pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd]);
    assign iss_fire  = iss_valid & ~iss_stall;
    assign sb_busy   = |pending_q;

    always_comb begin
        last_grant_d = last_grant_q;
        regwr_d      = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;
        if (xfer) begin
            last_grant_d = exu_gnt ? GNT_EXU : GNT_LSU;
            regwr_d      = (g_rd != '0);
            rd_d         = g_rd;
            data_d       = g_data;
        end

        // Clear before set: a new producer issued this cycle keeps the bit.
        pending_d = pending_q;
        if (regwr_q) pending_d[rd_q] = 1'b0;
        if (iss_fire && iss_rd != '0) pending_d[iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GNT_LSU;
            regwr_q      <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            pending_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
            last_grant_q <= last_grant_d;
            regwr_q      <= regwr_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            pending_q    <= pending_d;
        end
    end

    assign RegWr   = regwr_q;
    assign rd      = rd_q;
    assign rd_data = data_q;
endmodule

// File: tb/tb_ysyx_24080014_gpr_wb_arb.sv
// Bench for the write-back arbiter: directed scenarios plus random traffic,
// all compared against a behavioural model of arbitration and scoreboard.
module tb_ysyx_24080014_gpr_wb_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, lsu_valid, iss_valid;
    logic [4:0]  exu_rd, lsu_rd, iss_rs1, iss_rs2, iss_rd;
    logic [31:0] exu_data, lsu_data;
    logic        exu_ready, lsu_ready, iss_stall, RegWr, sb_busy;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    // Reference model: who won last, which registers await a write, what is being written.
    bit        m_last_exu;
    bit [31:0] m_pend;
    bit        m_we;
    bit [4:0]  m_rd;
    bit [31:0] m_data;
    bit        m_ge, m_gl;

    ysyx_24080014_gpr_wb_arb #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_stall(iss_stall), .RegWr(RegWr), .rd(rd), .rd_data(rd_data), .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_exu = 1'b0;
        m_pend     = '0;
        m_we       = 1'b0;
        m_rd       = '0;
        m_data     = '0;
    endtask

    task automatic idle_inputs();
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_busy", 32'(sb_busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs against the model, advance, check registered outputs.
    task automatic step();
        bit        stall, fire;
        bit [31:0] np;
        #1;
        m_ge  = exu_valid && (!lsu_valid || !m_last_exu);
        m_gl  = lsu_valid && !m_ge;
        stall = iss_valid && ((iss_rs1 != 0 && m_pend[iss_rs1]) ||
                              (iss_rs2 != 0 && m_pend[iss_rs2]) ||
                              (iss_rd  != 0 && m_pend[iss_rd]));
        check("exu_ready", 32'(exu_ready), 32'(m_ge));
        check("lsu_ready", 32'(lsu_ready), 32'(m_gl));
        check("iss_stall", 32'(iss_stall), 32'(stall));
        fire = iss_valid && !stall;
        np = m_pend;
        if (m_we) np[m_rd] = 1'b0;
        if (fire && iss_rd != 0) np[iss_rd] = 1'b1;
        @(posedge clk);
        #1;
        m_pend = np;
        if (m_ge) begin
            m_we = (exu_rd != 0); m_rd = exu_rd; m_data = exu_data; m_last_exu = 1'b1;
        end else if (m_gl) begin
            m_we = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data; m_last_exu = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        check("RegWr", 32'(RegWr), 32'(m_we));
        check("rd", 32'(rd), 32'(m_rd));
        check("rd_data", rd_data, m_data);
        check("sb_busy", 32'(sb_busy), 32'(m_pend != 0));
    endtask

    initial begin
        int exp_rd[4];
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("init_regwr", 32'(RegWr), 32'd0);
        check("init_rd", 32'(rd), 32'd0);
        check("init_data", rd_data, 32'd0);
        check("init_busy", 32'(sb_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single EXU write: granted now, visible on the write port for exactly one cycle.
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
        step();
        check("single_regwr", 32'(RegWr), 32'd1);
        check("single_rd", 32'(rd), 32'd5);
        check("single_data", rd_data, 32'hDEAD_BEEF);
        idle_inputs();
        step();
        check("single_regwr_drop", 32'(RegWr), 32'd0);

        // Conflict after reset: EXU wins first, then grants alternate.
        do_reset();
        exp_rd = '{1, 2, 1, 2};
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1111_1111;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_rd", 32'(rd), 32'(exp_rd[i]));
        end
        idle_inputs();
        step();

        // RAW: producer of x15 issues, consumer stalls until the cycle after RegWr.
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd15;
        step();
        iss_rd = 5'd0; iss_rs1 = 5'd15;
        step();
        check("raw_stall_pending", 32'(iss_stall), 32'd1);
        exu_valid = 1'b1; exu_rd = 5'd15; exu_data = 32'h0000_00F0;
        step();
        exu_valid = 1'b0;
        check("raw_stall_regwr", 32'(iss_stall), 32'd1);
        step();
        check("raw_release", 32'(iss_stall), 32'd0);
        step();
        idle_inputs();

        // WAW: write to x7 retires on the same edge a new producer of x7 issues.
        do_reset();
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h7777_0007;
        step();
        exu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        check("waw_busy", 32'(sb_busy), 32'd1);
        iss_valid = 1'b0; iss_rs1 = 5'd7; iss_rd = 5'd0;
        iss_valid = 1'b1;
        step();
        check("waw_still_pending", 32'(iss_stall), 32'd1);
        idle_inputs();

        // x0: LSU write to x0 consumes the grant but never writes; x0 issue never stalls.
        do_reset();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hABCD_0000;
        iss_valid = 1'b1; iss_rs1 = 5'd0; iss_rd = 5'd0;
        step();
        check("x0_regwr", 32'(RegWr), 32'd0);
        check("x0_busy", 32'(sb_busy), 32'd0);
        idle_inputs();
        step();

        // Reset mid-stream with pending = 0x8020 and RegWr = 1.
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        iss_rd = 5'd15;
        step();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h3333_3333;
        step();
        check("pre_rst_regwr", 32'(RegWr), 32'd1);
        iss_valid = 1'b1; iss_rs1 = 5'd5; iss_rd = 5'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_regwr", 32'(RegWr), 32'd0);
        check("mid_rst_rd", 32'(rd), 32'd0);
        check("mid_rst_data", rd_data, 32'd0);
        check("mid_rst_busy", 32'(sb_busy), 32'd0);
        check("mid_rst_exu_ready", 32'(exu_ready), 32'd0);
        check("mid_rst_lsu_ready", 32'(lsu_ready), 32'd0);
        check("mid_rst_stall", 32'(iss_stall), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(m_ge), 32'd1);
        idle_inputs();
        step();

        // Random traffic; requesters hold rd/data until granted.
        for (int n = 0; n < 3000; n++) begin
            if (!exu_valid || m_ge) begin
                exu_valid = 1'($urandom);
                exu_rd    = 5'($urandom_range(7, 0));
                exu_data  = $urandom;
            end
            if (!lsu_valid || m_gl) begin
                lsu_valid = 1'($urandom);
                lsu_rd    = 5'($urandom_range(7, 0));
                lsu_data  = $urandom;
            end
            iss_valid = 1'($urandom);
            iss_rs1   = 5'($urandom_range(7, 0));
            iss_rs2   = 5'($urandom_range(7, 0));
            iss_rd    = 5'($urandom_range(7, 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_24080014_gpr_wb_arb.md
# ysyx_24080014_gpr_wb_arb

Write-back arbiter and scoreboard for the NPC general-purpose register file. It shares the register file's single write port between the execute unit (EXU) and load/store unit (LSU) using round-robin arbitration, and registers the winning write for one cycle before presenting it to the register file. It also keeps a 32-entry pending-write scoreboard, which stalls issue on RAW and WAW hazards against in-flight destinations.

## Interface
- XLEN, 32, register data width
- NREG, 32, number of architectural registers; the index width is 5 bits
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- exu_valid  in  1  EXU write-back request
- exu_ready  out  1  EXU request granted this cycle
- exu_rd  in  5  EXU destination index
- exu_data  in  XLEN  EXU result
- lsu_valid  in  1  LSU write-back request
- lsu_ready  out  1  LSU request granted this cycle
- lsu_rd  in  5  LSU destination index
- lsu_data  in  XLEN  LSU load data
- iss_valid  in  1  decoder presents an instruction for issue
- iss_rs1, iss_rs2  in  5 each  source indices of that instruction
- iss_rd  in  5  destination index; 0 means no destination
- iss_stall  out  1  hazard detected; the instruction must not issue
- RegWr  out  1  register-file write enable
- rd  out  5  register-file write index
- rd_data  out  XLEN  register-file write data
- sb_busy  out  1  at least one write is pending (used for fence/ebreak drain)

## Operation
- **Handshake.** A transfer occurs when valid and ready are both 1 in the same cycle. Requesters hold rd and data stable until the transfer.
- **Grant.** Ready is combinational and is 1 only for the single granted requester. There is no back-pressure from the write register, so a lone requester is granted in the same cycle it asserts valid.
- **Conflict.** When both requesters are valid, the grant goes to the requester that did not win last.
  - `last_grant` is a 1-bit register that updates only on a completed transfer.
  - It resets to LSU, so the first conflict after reset is won by EXU.
- **Write stage.** A transfer loads the write register:
  - RegWr ← (granted rd != 0)
  - rd ← granted rd
  - rd_data ← granted data
  - With no transfer in a cycle, RegWr ← 0 on the next edge; rd and rd_data hold.
- **rd == 0 requests.** The transfer completes and consumes the grant, but RegWr stays 0 and the scoreboard is unaffected.
- **Scoreboard.** `pending[31:0]` is a bit vector; bit 0 is permanently 0.
  - Issue fire is `iss_fire = iss_valid & ~iss_stall`.
  - On the edge where iss_fire = 1 and iss_rd != 0, `pending[iss_rd]` is set.
  - On the edge where RegWr = 1, `pending[rd]` is cleared. This is the same edge on which the register file captures the write.
- **Set/clear on the same index in the same cycle.** Set wins, because a new producer is in flight.
- **Stall.** `iss_stall = iss_valid & (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd])`. Index 0 never stalls. There is no forwarding: a source matching the write in flight stalls until the cycle after RegWr.
- **sb_busy.** Equals `|pending`, combinational from the registered vector.
- **Reset (rst_n low).** Asynchronous:
  - RegWr = 0, rd = 0, rd_data = 0
  - pending = 0, last_grant = LSU
  - exu_ready = lsu_ready = 0 and iss_stall = 0 while rst_n is low
  - sb_busy = 0
  - Any transfer or issue in the reset cycle is discarded. A requester held valid across reset release is granted in the first cycle after release.

## Timing
- Transfer in cycle N gives RegWr = 1 in cycle N+1, and the register file is updated at the end of N+1. Latency is 1 cycle.
- The pending bit for that rd clears at the end of N+1. A dependent instruction stalls through N+1 and issues in N+2, reading the new value.
- Throughput is one write per cycle. Under continuous dual requests, grants alternate every cycle.
- iss_stall and ready are purely combinational from registered state and current inputs; there is no combinational path from ready to valid.

## Test plan
- **Reset:** assert rst_n = 0 mid-stream with pending = 0x0000_8020 and RegWr = 1 -> all outputs 0 immediately; after release, sb_busy = 0.
- **Single EXU write:** exu_valid, rd = 5, data = 0xDEADBEEF in cycle 0 -> exu_ready = 1 in cycle 0; RegWr = 1, rd = 5, rd_data = 0xDEADBEEF in cycle 1 only.
- **Conflict alternation (after reset):** both valid for 4 cycles, EXU rd = 1, LSU rd = 2 -> grants EXU, LSU, EXU, LSU; rd sequence 1, 2, 1, 2 in cycles 1–4.
- **RAW stall:** issue rd = 15, then issue rs1 = 15 while the write is outstanding -> iss_stall = 1 until the cycle after RegWr with rd = 15. That is, a write transferred in cycle N releases the stall in N+2.
- **WAW set-wins:** RegWr with rd = 7 in the same cycle as an issue fire with iss_rd = 7 -> pending[7] remains 1 and sb_busy = 1.
- **x0:** LSU rd = 0 transfer -> lsu_ready = 1, RegWr stays 0; issue with iss_rd = 0, rs1 = 0 -> never stalls and pending is unchanged.
